// File: rtl/core2mmio_pkg.sv
// Shared types and default MMIO window for the core-to-MMIO bridge.
package core2mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mmio_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mmio_op_t;

  localparam logic [63:0] MMIO_BASE_DEF = 64'h0;
  localparam logic [63:0] MMIO_SIZE_DEF = 64'h1_0000;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Counts cycles spent waiting for an MMIO completion and flags the last
// permitted wait cycle. A TIMEOUT of 0 disables expiry entirely.
module mmio_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              ENABLED = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LAST   = ENABLED ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_p0;

  // Wait-cycle counter: the n-th REQ cycle sees a count of n-1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (en && (cnt_p0 != LAST)) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign expired = ENABLED && en && (cnt_p0 == LAST);

endmodule

// File: rtl/core2mmio_bridge.sv
// Registered CPU-to-MMIO bridge: one outstanding transaction, address window
// check, response timeout and a one-cycle error pulse.
module core2mmio_bridge
  import core2mmio_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF),
  parameter logic [ADDR_W-1:0] MMIO_SIZE = ADDR_W'(MMIO_SIZE_DEF),
  parameter int                TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_W-1:0]     address_cpu,
  input  logic                  wen_cpu,
  input  logic                  ren_cpu,
  input  logic [DATA_W-1:0]     wdata_cpu,
  input  logic [DATA_W/8-1:0]   wmask_cpu,
  output logic [DATA_W-1:0]     rdata_cpu,
  output logic                  mem_stall,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     address_mem,
  output logic                  ren_mem,
  output logic                  wen_mem,
  output logic [DATA_W/8-1:0]   wmask_mem,
  output logic [DATA_W-1:0]     wdata_mem,
  input  logic [DATA_W-1:0]     rdata_mem,
  input  logic                  valid_mem
);

  mmio_state_t          state;
  mmio_op_t             op_p0;
  logic [ADDR_W-1:0]    addr_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic [DATA_W/8-1:0]  wmask_p0;
  logic                 ren_p0;
  logic                 wen_p0;
  logic [DATA_W-1:0]    rdata_p1;
  logic                 err_p1;

  logic                 req;
  logic                 hit;
  logic                 start;
  logic                 expired;

  // Unsigned window test done as an offset compare so BASE+SIZE never wraps.
  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - MMIO_BASE;
    return (a >= MMIO_BASE) && (off < MMIO_SIZE);
  endfunction

  assign req   = ren_cpu | wen_cpu;
  assign hit   = in_window(address_cpu);
  assign start = (state == IDLE) && req && hit;

  mmio_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (start),
    .en      (state == REQ),
    .expired (expired)
  );

  // Request capture (p0) and response/error (p1) stages driven by the FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      op_p0    <= READ;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      wmask_p0 <= '0;
      ren_p0   <= 1'b0;
      wen_p0   <= 1'b0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      ren_p0 <= 1'b0;
      wen_p0 <= 1'b0;
      err_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              addr_p0  <= address_cpu;
              wdata_p0 <= wdata_cpu;
              wmask_p0 <= wmask_cpu;
              // Simultaneous read and write resolves to a write.
              op_p0    <= wen_cpu ? WRITE : READ;
              ren_p0   <= ~wen_cpu;
              wen_p0   <= wen_cpu;
              state    <= REQ;
            end else begin
              err_p1 <= 1'b1;
              state  <= ERR;
            end
          end
        end
        REQ: begin
          // A completion in the expiry cycle still counts as success.
          if (valid_mem) begin
            if (op_p0 == READ) begin
              rdata_p1 <= rdata_mem;
            end
            state <= DONE;
          end else if (expired) begin
            err_p1 <= 1'b1;
            state  <= ERR;
          end else begin
            ren_p0 <= (op_p0 == READ);
            wen_p0 <= (op_p0 == WRITE);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_stall   = ((state == IDLE) && req) || (state == REQ);
  assign rdata_cpu   = (state == DONE) ? rdata_p1 : '0;
  assign bus_err     = err_p1;
  assign ren_mem     = ren_p0;
  assign wen_mem     = wen_p0;
  assign address_mem = addr_p0;
  assign wdata_mem   = wdata_p0;
  assign wmask_mem   = wmask_p0;

endmodule

// File: tb/tb_core2mmio_bridge.sv
// Directed bench for core2mmio_bridge with a small timeout and offset window.
module tb_core2mmio_bridge;

  localparam logic [63:0] BASE = 64'h4000_0000;
  localparam logic [63:0] SIZE = 64'h1_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] address_cpu;
  logic        wen_cpu;
  logic        ren_cpu;
  logic [63:0] wdata_cpu;
  logic [7:0]  wmask_cpu;
  logic [63:0] rdata_cpu;
  logic        mem_stall;
  logic        bus_err;
  logic [63:0] address_mem;
  logic        ren_mem;
  logic        wen_mem;
  logic [7:0]  wmask_mem;
  logic [63:0] wdata_mem;
  logic [63:0] rdata_mem;
  logic        valid_mem;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core2mmio_bridge #(
    .ADDR_W    (64),
    .DATA_W    (64),
    .MMIO_BASE (BASE),
    .MMIO_SIZE (SIZE),
    .TIMEOUT   (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .address_cpu (address_cpu),
    .wen_cpu     (wen_cpu),
    .ren_cpu     (ren_cpu),
    .wdata_cpu   (wdata_cpu),
    .wmask_cpu   (wmask_cpu),
    .rdata_cpu   (rdata_cpu),
    .mem_stall   (mem_stall),
    .bus_err     (bus_err),
    .address_mem (address_mem),
    .ren_mem     (ren_mem),
    .wen_mem     (wen_mem),
    .wmask_mem   (wmask_mem),
    .wdata_mem   (wdata_mem),
    .rdata_mem   (rdata_mem),
    .valid_mem   (valid_mem)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ren_cpu   = 1'b0;
    wen_cpu   = 1'b0;
    valid_mem = 1'b0;
  endtask

  initial begin
    rstn        = 1'b0;
    address_cpu = '0;
    wen_cpu     = 1'b0;
    ren_cpu     = 1'b0;
    wdata_cpu   = '0;
    wmask_cpu   = '0;
    rdata_mem   = '0;
    valid_mem   = 1'b0;

    // Reset state
    step();
    settle();
    chk("rst_stall", mem_stall, 0);
    chk("rst_ren", ren_mem, 0);
    chk("rst_wen", wen_mem, 0);
    chk("rst_addr", address_mem, 0);
    chk("rst_wdata", wdata_mem, 0);
    chk("rst_wmask", wmask_mem, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_rdata", rdata_cpu, 0);
    ren_cpu = 1'b1;
    settle();
    chk("rst_stall_req", mem_stall, 1);
    ren_cpu = 1'b0;
    step();
    rstn = 1'b1;

    // Read, 0-wait slave
    step();
    ren_cpu = 1'b1; address_cpu = BASE + 64'd8;
    settle();
    chk("rd0_c0_stall", mem_stall, 1);
    chk("rd0_c0_ren", ren_mem, 0);
    step();
    valid_mem = 1'b1; rdata_mem = 64'hDEAD_BEEF;
    settle();
    chk("rd0_c1_stall", mem_stall, 1);
    chk("rd0_c1_ren", ren_mem, 1);
    chk("rd0_c1_addr", address_mem, BASE + 64'd8);
    step();
    idle_inputs();
    settle();
    chk("rd0_c2_stall", mem_stall, 0);
    chk("rd0_c2_rdata", rdata_cpu, 64'hDEAD_BEEF);
    chk("rd0_c2_err", bus_err, 0);
    chk("rd0_c2_ren", ren_mem, 0);
    step();
    settle();
    chk("rd0_c3_rdata", rdata_cpu, 0);

    // Write, 3-wait slave; completion coincides with the timeout cycle
    wen_cpu = 1'b1; address_cpu = BASE + 64'd16;
    wdata_cpu = 64'h1234; wmask_cpu = 8'h0F;
    settle();
    chk("wr_c0_stall", mem_stall, 1);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) wdata_cpu = 64'hFFFF_0000;
      if (c == 4) begin valid_mem = 1'b1; rdata_mem = 64'h5555; end
      settle();
      chk($sformatf("wr_c%0d_wen", c), wen_mem, 1);
      chk($sformatf("wr_c%0d_ren", c), ren_mem, 0);
      chk($sformatf("wr_c%0d_wdata", c), wdata_mem, 64'h1234);
      chk($sformatf("wr_c%0d_wmask", c), wmask_mem, 8'h0F);
      chk($sformatf("wr_c%0d_stall", c), mem_stall, 1);
    end
    step();
    idle_inputs();
    settle();
    chk("wr_c5_stall", mem_stall, 0);
    chk("wr_c5_err", bus_err, 0);
    chk("wr_c5_wen", wen_mem, 0);
    chk("wr_c5_rdata_kept", rdata_cpu, 64'hDEAD_BEEF);

    // Out-of-window read at the exclusive upper bound
    step();
    ren_cpu = 1'b1; address_cpu = BASE + SIZE;
    settle();
    chk("oow_c0_stall", mem_stall, 1);
    step();
    ren_cpu = 1'b0;
    settle();
    chk("oow_c1_err", bus_err, 1);
    chk("oow_c1_ren", ren_mem, 0);
    chk("oow_c1_stall", mem_stall, 0);
    chk("oow_c1_rdata", rdata_cpu, 0);
    step();
    settle();
    chk("oow_c2_err", bus_err, 0);

    // Below the base is also a fault
    ren_cpu = 1'b1; address_cpu = BASE - 64'd1;
    step();
    ren_cpu = 1'b0;
    settle();
    chk("low_err", bus_err, 1);
    chk("low_ren", ren_mem, 0);
    step();

    // Last byte of the window is legal
    ren_cpu = 1'b1; address_cpu = BASE + SIZE - 64'd1;
    step();
    valid_mem = 1'b1; rdata_mem = 64'h0BAD_F00D;
    settle();
    chk("top_ren", ren_mem, 1);
    chk("top_err", bus_err, 0);
    step();
    idle_inputs();
    settle();
    chk("top_rdata", rdata_cpu, 64'h0BAD_F00D);
    step();

    // Timeout (TIMEOUT=4) and a late response
    ren_cpu = 1'b1; address_cpu = BASE;
    for (int c = 1; c <= 4; c++) begin
      step();
      settle();
      chk($sformatf("to_c%0d_ren", c), ren_mem, 1);
      chk($sformatf("to_c%0d_stall", c), mem_stall, 1);
      chk($sformatf("to_c%0d_err", c), bus_err, 0);
    end
    step();
    ren_cpu = 1'b0;
    settle();
    chk("to_c5_err", bus_err, 1);
    chk("to_c5_stall", mem_stall, 0);
    chk("to_c5_ren", ren_mem, 0);
    chk("to_c5_rdata", rdata_cpu, 0);
    step();
    valid_mem = 1'b1; rdata_mem = 64'h7777;
    settle();
    chk("to_c6_err", bus_err, 0);
    chk("to_c6_stall", mem_stall, 0);
    step();
    valid_mem = 1'b0;
    settle();
    chk("to_c7_rdata", rdata_cpu, 0);
    chk("to_c7_ren", ren_mem, 0);
    chk("to_c7_err", bus_err, 0);

    // Read+write together, then asynchronous reset during REQ
    ren_cpu = 1'b1; wen_cpu = 1'b1; address_cpu = BASE + 64'd24;
    wdata_cpu = 64'hABCD; wmask_cpu = 8'h00;
    step();
    settle();
    chk("rw_c1_wen", wen_mem, 1);
    chk("rw_c1_ren", ren_mem, 0);
    chk("rw_c1_wmask", wmask_mem, 8'h00);
    step();
    rstn = 1'b0;
    settle();
    chk("rw_rst_wen", wen_mem, 0);
    chk("rw_rst_ren", ren_mem, 0);
    chk("rw_rst_addr", address_mem, 0);
    idle_inputs();
    settle();
    chk("rw_rst_stall", mem_stall, 0);
    step();
    rstn = 1'b1;
    step();
    settle();
    chk("rw_post_stall", mem_stall, 0);
    chk("rw_post_err", bus_err, 0);
    chk("rw_post_wen", wen_mem, 0);
    chk("rw_post_rdata", rdata_cpu, 0);

    // Held request: back-to-back reads to different addresses
    ren_cpu = 1'b1; address_cpu = BASE + 64'd32;
    step();
    valid_mem = 1'b1; rdata_mem = 64'hA1A1;
    settle();
    chk("b2b_c1_addr", address_mem, BASE + 64'd32);
    step();
    valid_mem = 1'b0; address_cpu = BASE + 64'd40;
    settle();
    chk("b2b_c2_rdata", rdata_cpu, 64'hA1A1);
    chk("b2b_c2_stall", mem_stall, 0);
    step();
    settle();
    chk("b2b_c3_stall", mem_stall, 1);
    chk("b2b_c3_ren", ren_mem, 0);
    step();
    valid_mem = 1'b1; rdata_mem = 64'hB2B2;
    settle();
    chk("b2b_c4_ren", ren_mem, 1);
    chk("b2b_c4_addr", address_mem, BASE + 64'd40);
    step();
    idle_inputs();
    settle();
    chk("b2b_c5_rdata", rdata_cpu, 64'hB2B2);
    chk("b2b_c5_stall", mem_stall, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
